// File: rtl/ucsbece154b_pipe_ctrl.sv
// Pipeline sequencer: load-use stall, operand forwarding, mispredict flush, memory-wait freeze
// with a watchdog FSM. Optional performance counters are enabled by defining PERF_CNT_EN.
module ucsbece154b_pipe_ctrl #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D_i,
  input  logic [4:0]       Rs2D_i,
  input  logic [4:0]       Rs1E_i,
  input  logic [4:0]       Rs2E_i,
  input  logic [4:0]       RdE_i,
  input  logic [4:0]       RdM_i,
  input  logic [4:0]       RdW_i,
  input  logic             LoadE_i,
  input  logic             RegWriteM_i,
  input  logic             RegWriteW_i,
  input  logic             BranchE_i,
  input  logic             Mispredict_i,
  input  logic             ImemReady_i,
  input  logic             DmemReq_i,
  input  logic             DmemReady_i,
  output logic             StallF_o,
  output logic             StallD_o,
  output logic             StallE_o,
  output logic             StallM_o,
  output logic             StallW_o,
  output logic             FlushD_o,
  output logic             FlushE_o,
  output logic [1:0]       ForwardAE_o,
  output logic [1:0]       ForwardBE_o,
  output logic [1:0]       State_o,
  output logic             Error_o,
  output logic [CNT_W-1:0] CycleCnt_o,
  output logic [CNT_W-1:0] BranchCnt_o,
  output logic [CNT_W-1:0] MispredCnt_o,
  output logic [CNT_W-1:0] StallCnt_o
);

  localparam logic [1:0] ForwardEx  = 2'b00;
  localparam logic [1:0] ForwardWb  = 2'b01;
  localparam logic [1:0] ForwardMem = 2'b10;

  localparam int unsigned WaitW = $clog2(MAX_WAIT) + 1;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StIwait = 2'd1,
    StDwait = 2'd2,
    StErr   = 2'd3
  } state_e;

  state_e           state_q;
  logic [WaitW-1:0] wait_cnt_q;
  logic             error_q;

  logic lw, dw, iw, err, wait_now;

  assign lw       = LoadE_i & (RdE_i != 5'd0) & ((RdE_i == Rs1D_i) | (RdE_i == Rs2D_i));
  assign dw       = DmemReq_i & ~DmemReady_i;
  assign iw       = ~ImemReady_i;
  assign err      = (state_q == StErr);
  assign wait_now = dw | (iw & ~Mispredict_i);

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wr_m,
                                         input logic [4:0] rd_m,
                                         input logic       wr_w,
                                         input logic [4:0] rd_w);
    if (wr_m && rd_m != 5'd0 && rd_m == rs) begin
      return ForwardMem;
    end else if (wr_w && rd_w != 5'd0 && rd_w == rs) begin
      return ForwardWb;
    end
    return ForwardEx;
  endfunction

  always_comb begin
    StallF_o    = 1'b0;
    StallD_o    = 1'b0;
    StallE_o    = 1'b0;
    StallM_o    = 1'b0;
    StallW_o    = 1'b0;
    FlushD_o    = 1'b0;
    FlushE_o    = 1'b0;
    ForwardAE_o = ForwardEx;
    ForwardBE_o = ForwardEx;
    if (!reset) begin
      ForwardAE_o = fwd_sel(Rs1E_i, RegWriteM_i, RdM_i, RegWriteW_i, RdW_i);
      ForwardBE_o = fwd_sel(Rs2E_i, RegWriteM_i, RdM_i, RegWriteW_i, RdW_i);
      // A data-memory wait freezes E, so a pending mispredict is replayed after release.
      if (err || dw) begin
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        StallE_o = 1'b1;
        StallM_o = 1'b1;
        StallW_o = 1'b1;
      end else if (Mispredict_i) begin
        FlushD_o = 1'b1;
        FlushE_o = 1'b1;
      end else if (lw) begin
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        FlushE_o = 1'b1;
      end else if (iw) begin
        StallF_o = 1'b1;
        FlushD_o = 1'b1;
      end
    end
  end

  // Wait counter only advances while already in a wait state; RUN entry clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      error_q    <= 1'b0;
    end else if (state_q != StErr) begin
      if (wait_now) begin
        if (state_q != StRun && wait_cnt_q == WaitW'(MAX_WAIT - 1)) begin
          state_q <= StErr;
          error_q <= 1'b1;
        end else begin
          state_q <= dw ? StDwait : StIwait;
          if (state_q != StRun) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
      end else begin
        state_q    <= StRun;
        wait_cnt_q <= '0;
      end
    end
  end

  assign State_o = state_q;
  assign Error_o = error_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, branch_cnt_q, mispred_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt_q   <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      if (~&cycle_cnt_q) begin
        cycle_cnt_q <= cycle_cnt_q + 1'b1;
      end
      if (BranchE_i && !dw && ~&branch_cnt_q) begin
        branch_cnt_q <= branch_cnt_q + 1'b1;
      end
      if (Mispredict_i && !dw && ~&mispred_cnt_q) begin
        mispred_cnt_q <= mispred_cnt_q + 1'b1;
      end
      if (StallF_o && ~&stall_cnt_q) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign CycleCnt_o   = cycle_cnt_q;
  assign BranchCnt_o  = branch_cnt_q;
  assign MispredCnt_o = mispred_cnt_q;
  assign StallCnt_o   = stall_cnt_q;
`else
  logic unused_branch;
  assign unused_branch = BranchE_i;

  assign CycleCnt_o   = '0;
  assign BranchCnt_o  = '0;
  assign MispredCnt_o = '0;
  assign StallCnt_o   = '0;
`endif

endmodule

// File: tb/tb_ucsbece154b_pipe_ctrl.sv
// Directed self-checking bench for ucsbece154b_pipe_ctrl (MAX_WAIT=4); counter expectations
// follow whether PERF_CNT_EN is defined.
module tb_ucsbece154b_pipe_ctrl;

  localparam int unsigned CntW = 32;
  localparam logic [1:0] FwdEx  = 2'b00;
  localparam logic [1:0] FwdWb  = 2'b01;
  localparam logic [1:0] FwdMem = 2'b10;

  logic            clk, reset;
  logic [4:0]      rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic            load_e, reg_write_m, reg_write_w, branch_e, mispredict;
  logic            imem_ready, dmem_req, dmem_ready;
  logic            stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e;
  logic [1:0]      forward_ae, forward_be, state;
  logic            error;
  logic [CntW-1:0] cycle_cnt, branch_cnt, mispred_cnt, stall_cnt;
  logic [6:0]      ctl;

  int num_checks = 0;
  int num_errors = 0;

  ucsbece154b_pipe_ctrl #(
    .MAX_WAIT(4),
    .CNT_W   (CntW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Rs1D_i      (rs1_d),
    .Rs2D_i      (rs2_d),
    .Rs1E_i      (rs1_e),
    .Rs2E_i      (rs2_e),
    .RdE_i       (rd_e),
    .RdM_i       (rd_m),
    .RdW_i       (rd_w),
    .LoadE_i     (load_e),
    .RegWriteM_i (reg_write_m),
    .RegWriteW_i (reg_write_w),
    .BranchE_i   (branch_e),
    .Mispredict_i(mispredict),
    .ImemReady_i (imem_ready),
    .DmemReq_i   (dmem_req),
    .DmemReady_i (dmem_ready),
    .StallF_o    (stall_f),
    .StallD_o    (stall_d),
    .StallE_o    (stall_e),
    .StallM_o    (stall_m),
    .StallW_o    (stall_w),
    .FlushD_o    (flush_d),
    .FlushE_o    (flush_e),
    .ForwardAE_o (forward_ae),
    .ForwardBE_o (forward_be),
    .State_o     (state),
    .Error_o     (error),
    .CycleCnt_o  (cycle_cnt),
    .BranchCnt_o (branch_cnt),
    .MispredCnt_o(mispred_cnt),
    .StallCnt_o  (stall_cnt)
  );

  // {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}
  assign ctl = {stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    load_e = 0; reg_write_m = 0; reg_write_w = 0; branch_e = 0; mispredict = 0;
    imem_ready = 1; dmem_req = 0; dmem_ready = 1;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #2;
    // Hazard inputs active during reset must not reach the outputs.
    load_e = 1; rd_e = 5; rs1_d = 5; reg_write_m = 1; rd_m = 7; rs1_e = 7;
    #1;
    check_eq("rst_ctl", 32'(ctl), 32'h00);
    check_eq("rst_fwd_a", 32'(forward_ae), 32'(FwdEx));
    check_eq("rst_state", 32'(state), 0);
    check_eq("rst_error", 32'(error), 0);
    check_eq("rst_cycle_cnt", cycle_cnt, 0);
    idle_inputs();
    tick();
    reset = 1'b0;

    // Load-use hazard
    tick();
    load_e = 1; rd_e = 5; rs1_d = 5;
    #2 check_eq("lw_ctl", 32'(ctl), 32'b1100001);
    rd_e = 0;
    #1 check_eq("lw_x0_ctl", 32'(ctl), 32'h00);
    rd_e = 9; rs1_d = 1; rs2_d = 9;
    #1 check_eq("lw_rs2_ctl", 32'(ctl), 32'b1100001);
    idle_inputs();

    // Forwarding
    tick();
    reg_write_m = 1; reg_write_w = 1; rd_m = 7; rd_w = 7; rs1_e = 7; rs2_e = 3;
    #2 check_eq("fwd_a_mem", 32'(forward_ae), 32'(FwdMem));
    check_eq("fwd_b_ex", 32'(forward_be), 32'(FwdEx));
    rd_m = 3;
    #1 check_eq("fwd_a_wb", 32'(forward_ae), 32'(FwdWb));
    check_eq("fwd_b_mem", 32'(forward_be), 32'(FwdMem));
    reg_write_m = 0;
    #1 check_eq("fwd_b_nowr", 32'(forward_be), 32'(FwdEx));
    idle_inputs();

    // Mispredict overrides load-use and ifetch wait
    tick();
    load_e = 1; rd_e = 5; rs1_d = 5; imem_ready = 0; mispredict = 1;
    #2 check_eq("mp_ctl", 32'(ctl), 32'b0000011);
    idle_inputs();

    // Data-memory freeze holds a pending mispredict
    tick();
    dmem_req = 1; dmem_ready = 0; mispredict = 1;
    #2 check_eq("dw_ctl", 32'(ctl), 32'b1111100);
    check_eq("dw_state0", 32'(state), 0);
    tick();
    check_eq("dw_state1", 32'(state), 2);
    check_eq("dw_ctl1", 32'(ctl), 32'b1111100);
    tick();
    tick();
    check_eq("dw_state3", 32'(state), 2);
    dmem_ready = 1;
    #1 check_eq("dw_release_ctl", 32'(ctl), 32'b0000011);
    tick();
    check_eq("dw_release_state", 32'(state), 0);
    check_eq("dw_no_error", 32'(error), 0);
    idle_inputs();

    // Watchdog: ifetch wait held until ERR
    tick();
    imem_ready = 0;
    #2 check_eq("iw_ctl", 32'(ctl), 32'b1000010);
    tick();
    check_eq("iw_state", 32'(state), 1);
    tick();
    tick();
    tick();
    check_eq("iw_state_4th", 32'(state), 1);
    check_eq("iw_no_error", 32'(error), 0);
    tick();
    check_eq("err_state", 32'(state), 3);
    check_eq("err_error", 32'(error), 1);
    check_eq("err_ctl", 32'(ctl), 32'b1111100);
    imem_ready = 1;
    tick();
    check_eq("err_sticky_state", 32'(state), 3);
    check_eq("err_sticky_ctl", 32'(ctl), 32'b1111100);
    #2 reset = 1'b1;
    #1 check_eq("async_rst_state", 32'(state), 0);
    check_eq("async_rst_error", 32'(error), 0);
    check_eq("async_rst_ctl", 32'(ctl), 32'h00);

    // Performance counters: 10 cycles, branches in 2/5/8 (9 is frozen), mispredict in 5
    idle_inputs();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      branch_e   = (i == 2 || i == 5 || i == 8 || i == 9);
      mispredict = (i == 5);
      imem_ready = (i != 7);
      dmem_req   = (i == 9);
      dmem_ready = (i != 9);
      tick();
    end
    idle_inputs();
`ifdef PERF_CNT_EN
    check_eq("cycle_cnt", cycle_cnt, 10);
    check_eq("branch_cnt", branch_cnt, 3);
    check_eq("mispred_cnt", mispred_cnt, 1);
    check_eq("stall_cnt", stall_cnt, 2);
`else
    check_eq("cycle_cnt_off", cycle_cnt, 0);
    check_eq("branch_cnt_off", branch_cnt, 0);
    check_eq("mispred_cnt_off", mispred_cnt, 0);
    check_eq("stall_cnt_off", stall_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
